// File: rtl/mouse_bus_responder.sv
// -----------------------------------------------------------------------------
// mouse_bus_responder
//
// Read/write bus responder that presents the PS/2 mouse transceiver's latest
// packet to the microprocessor over the shared tri-state bus. It snapshots
// each packet into shadow registers and keeps a coherent X/Y pair that is
// latched by a status read. It also counts packets, flags overrun (a new
// packet arriving while the previous interrupt is still pending), and raises
// the mouse interrupt, holding it until the processor acknowledges.
//
// Register map (offset from BASE_ADDR):
//   +0 R   shadow status (the read latches shadow X/Y into coherent X/Y)
//   +1 R   coherent X
//   +2 R   coherent Y
//   +3 R   packet count (wraps mod 256)
//   +4 R   {6'b0, overrun, interrupt raise} (the read clears overrun)
//   +5 R/W {7'b0, int_en}
//
// Ports:
//   CLK                 system clock
//   RESET               asynchronous, active-low reset
//   BUS_ADDR[7:0]       bus address
//   BUS_DATA[7:0]       shared data bus, driven only the cycle after a read
//                       of this block's window, otherwise high impedance
//   BUS_WE              1 = write cycle, 0 = read cycle
//   MOUSE_STATUS/X/Y    packet bytes from the transceiver
//   SEND_INTERRUPT      single-cycle pulse: new packet valid this cycle
//   BUS_INTERRUPT_RAISE mouse interrupt request (registered)
//   BUS_INTERRUPT_ACK   single-cycle acknowledge from the processor
// -----------------------------------------------------------------------------
module mouse_bus_responder #(
  parameter logic [7:0] BASE_ADDR = 8'hA0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic [7:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_X,
  input  logic [7:0] MOUSE_Y,
  input  logic       SEND_INTERRUPT,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [7:0] OFF_STATUS = 8'd0;
  localparam logic [7:0] OFF_X      = 8'd1;
  localparam logic [7:0] OFF_Y      = 8'd2;
  localparam logic [7:0] OFF_COUNT  = 8'd3;
  localparam logic [7:0] OFF_FLAGS  = 8'd4;
  localparam logic [7:0] OFF_CTRL   = 8'd5;
  localparam logic [7:0] WIN_SIZE   = 8'd6;

  // Registered state
  logic [7:0] shadow_status_q, shadow_status_d;
  logic [7:0] shadow_x_q, shadow_x_d;
  logic [7:0] shadow_y_q, shadow_y_d;
  logic [7:0] coherent_x_q, coherent_x_d;
  logic [7:0] coherent_y_q, coherent_y_d;
  logic [7:0] pkt_cnt_q, pkt_cnt_d;
  logic       overrun_q, overrun_d;
  logic       int_en_q, int_en_d;
  logic       raise_q, raise_d;
  logic [7:0] rdata_q, rdata_d;
  logic       drive_q, drive_d;

  // Decode helpers
  logic [7:0] offset_s;
  logic       in_window_s;
  logic       rd_s;
  logic       wr_ctrl_s;
  logic [7:0] rd_sel_s;
  logic       unused_wdata_s;

  // Only bit 0 of a control write is meaningful; the upper bits are folded
  // here so they are visibly consumed.
  assign unused_wdata_s = ^BUS_DATA[7:1];

  // Tri-state driver: BUS_DATA carries the read register only while the
  // registered drive enable is set; reset clears it asynchronously.
  assign BUS_DATA = drive_q ? rdata_q : 8'hZZ;

  assign BUS_INTERRUPT_RAISE = raise_q;

  // Address decode: offset subtraction wraps mod 256, so the window test is
  // a single unsigned compare.
  always_comb begin
    offset_s    = BUS_ADDR - BASE_ADDR;
    in_window_s = (offset_s < WIN_SIZE);
    rd_s        = in_window_s & ~BUS_WE;
    wr_ctrl_s   = BUS_WE & (offset_s == OFF_CTRL);
  end

  // Read mux: values as they stand before this edge's updates.
  always_comb begin
    rd_sel_s = 8'h00;
    case (offset_s)
      OFF_STATUS: rd_sel_s = shadow_status_q;
      OFF_X:      rd_sel_s = coherent_x_q;
      OFF_Y:      rd_sel_s = coherent_y_q;
      OFF_COUNT:  rd_sel_s = pkt_cnt_q;
      OFF_FLAGS:  rd_sel_s = {6'b000000, overrun_q, raise_q};
      OFF_CTRL:   rd_sel_s = {7'b0000000, int_en_q};
      default:    rd_sel_s = 8'h00;
    endcase
  end

  // Next-state logic for all registers.
  always_comb begin
    shadow_status_d = shadow_status_q;
    shadow_x_d      = shadow_x_q;
    shadow_y_d      = shadow_y_q;
    coherent_x_d    = coherent_x_q;
    coherent_y_d    = coherent_y_q;
    pkt_cnt_d       = pkt_cnt_q;
    overrun_d       = overrun_q;
    int_en_d        = int_en_q;
    raise_d         = raise_q;
    rdata_d         = rdata_q;
    drive_d         = 1'b0;

    // Bus read: load the read register and drive for exactly one cycle.
    if (rd_s) begin
      rdata_d = rd_sel_s;
      drive_d = 1'b1;
    end else begin
      rdata_d = rdata_q;
      drive_d = 1'b0;
    end

    // A status read latches the pre-edge shadow X/Y, so a packet arriving
    // on the same edge does not leak into the coherent pair.
    if (rd_s && (offset_s == OFF_STATUS)) begin
      coherent_x_d = shadow_x_q;
      coherent_y_d = shadow_y_q;
    end else begin
      coherent_x_d = coherent_x_q;
      coherent_y_d = coherent_y_q;
    end

    // Packet capture.
    if (SEND_INTERRUPT) begin
      shadow_status_d = MOUSE_STATUS;
      shadow_x_d      = MOUSE_X;
      shadow_y_d      = MOUSE_Y;
      pkt_cnt_d       = pkt_cnt_q + 8'd1;
    end else begin
      shadow_status_d = shadow_status_q;
      shadow_x_d      = shadow_x_q;
      shadow_y_d      = shadow_y_q;
      pkt_cnt_d       = pkt_cnt_q;
    end

    // Overrun: a packet lands while an unacknowledged interrupt is pending.
    // Setting takes priority over the clear-on-read of the flags register.
    if (SEND_INTERRUPT && raise_q && !BUS_INTERRUPT_ACK) begin
      overrun_d = 1'b1;
    end else if (rd_s && (offset_s == OFF_FLAGS)) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    // Interrupt: a new event wins over a simultaneous acknowledge; clearing
    // int_en never drops an already pending request.
    if (SEND_INTERRUPT && int_en_q) begin
      raise_d = 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_d = 1'b0;
    end else begin
      raise_d = raise_q;
    end

    // Control register write.
    if (wr_ctrl_s) begin
      int_en_d = BUS_DATA[0];
    end else begin
      int_en_d = int_en_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shadow_status_q <= 8'h00;
      shadow_x_q      <= 8'h00;
      shadow_y_q      <= 8'h00;
      coherent_x_q    <= 8'h00;
      coherent_y_q    <= 8'h00;
      pkt_cnt_q       <= 8'h00;
      overrun_q       <= 1'b0;
      int_en_q        <= 1'b1;
      raise_q         <= 1'b0;
      rdata_q         <= 8'h00;
      drive_q         <= 1'b0;
    end else begin
      shadow_status_q <= shadow_status_d;
      shadow_x_q      <= shadow_x_d;
      shadow_y_q      <= shadow_y_d;
      coherent_x_q    <= coherent_x_d;
      coherent_y_q    <= coherent_y_d;
      pkt_cnt_q       <= pkt_cnt_d;
      overrun_q       <= overrun_d;
      int_en_q        <= int_en_d;
      raise_q         <= raise_d;
      rdata_q         <= rdata_d;
      drive_q         <= drive_d;
    end
  end

endmodule

// File: tb/tb_mouse_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_mouse_bus_responder
//
// Self-checking bench for mouse_bus_responder. A register-map level model
// tracks what every read must return and what the interrupt line must be;
// a negedge process compares the DUT against it every cycle, and directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mouse_bus_responder;

  localparam logic [7:0] BASE = 8'hA0;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [7:0] mouse_status;
  logic [7:0] mouse_x;
  logic [7:0] mouse_y;
  logic       send;
  logic       raise;
  logic       ack;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;

  int n_checks;
  int n_errors;
  bit check_en;

  // Model state: the programmer-visible contents of the register map.
  logic [7:0] m_st, m_x, m_y, m_cx, m_cy, m_cnt, m_rdata;
  bit         m_ovr, m_en, m_raise, m_drive;

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  mouse_bus_responder #(.BASE_ADDR(BASE)) dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .BUS_ADDR            (bus_addr),
    .BUS_DATA            (bus_data),
    .BUS_WE              (bus_we),
    .MOUSE_STATUS        (mouse_status),
    .MOUSE_X             (mouse_x),
    .MOUSE_Y             (mouse_y),
    .SEND_INTERRUPT      (send),
    .BUS_INTERRUPT_RAISE (raise),
    .BUS_INTERRUPT_ACK   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input bit ok, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] view(input logic [7:0] off);
    case (off)
      8'd0:    return m_st;
      8'd1:    return m_cx;
      8'd2:    return m_cy;
      8'd3:    return m_cnt;
      8'd4:    return {6'd0, m_ovr, m_raise};
      8'd5:    return {7'd0, m_en};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset;
    m_st = 8'h00; m_x = 8'h00; m_y = 8'h00; m_cx = 8'h00; m_cy = 8'h00;
    m_cnt = 8'h00; m_rdata = 8'h00; m_ovr = 1'b0; m_en = 1'b1;
    m_raise = 1'b0; m_drive = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge;
    logic [7:0] off;
    logic [7:0] v;
    bit rd, old_raise, old_en;
    off       = bus_addr - BASE;
    rd        = (off < 8'd6) && !bus_we;
    v         = view(off);
    old_raise = m_raise;
    old_en    = m_en;
    if (rd) m_rdata = v;
    m_drive = rd;
    if (rd && off == 8'd0) begin
      m_cx = m_x;
      m_cy = m_y;
    end
    if (send) begin
      m_st  = mouse_status;
      m_x   = mouse_x;
      m_y   = mouse_y;
      m_cnt = m_cnt + 8'd1;
    end
    if (send && old_raise && !ack) m_ovr = 1'b1;
    else if (rd && off == 8'd4)    m_ovr = 1'b0;
    if (send && old_en)  m_raise = 1'b1;
    else if (ack)        m_raise = 1'b0;
    if (bus_we && off == 8'd5) m_en = tb_wdata[0];
  endtask

  // One bus cycle: apply inputs, step model at the edge, return 1 time unit later.
  task automatic cyc(input logic [7:0] a, input logic we, input logic [7:0] wd,
                     input logic si, input logic [7:0] s, input logic [7:0] xx,
                     input logic [7:0] yy, input logic ak);
    bus_addr = a; bus_we = we; tb_wdata = wd; tb_drv = we && (a == BASE + 8'd5);
    send = si; mouse_status = s; mouse_x = xx; mouse_y = yy; ack = ak;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle;
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic pkt(input logic [7:0] s, input logic [7:0] xx, input logic [7:0] yy, input logic ak);
    cyc(8'h00, 1'b0, 8'h00, 1'b1, s, xx, yy, ak);
  endtask

  task automatic rd_expect(input logic [7:0] off, input logic [7:0] lit, input string name);
    cyc(BASE + off, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk(name, bus_data === lit, bus_data, lit);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("raise_cycle", raise === m_raise, {7'd0, raise}, {7'd0, m_raise});
      if (!tb_drv) begin
        if (m_drive) chk("bus_data_cycle", bus_data === m_rdata, bus_data, m_rdata);
        else         chk("bus_z_cycle", bus_data === 8'hzz, bus_data, 8'h00);
      end
    end
  end

  initial begin
    bit prev_rd;
    logic [7:0] a;
    logic       we;
    n_checks = 0; n_errors = 0; check_en = 1'b0;
    rst_n = 1'b0; bus_addr = 8'h00; bus_we = 1'b0; tb_drv = 1'b0; tb_wdata = 8'h00;
    send = 1'b0; mouse_status = 8'h00; mouse_x = 8'h00; mouse_y = 8'h00; ack = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus_z", bus_data === 8'hzz, bus_data, 8'h00);
    chk("reset_raise", raise === 1'b0, {7'd0, raise}, 8'h00);
    #1 rst_n = 1'b1;
    check_en = 1'b1;

    // 1. Reset values
    rd_expect(8'd3, 8'h00, "reset_pkt_cnt");
    rd_expect(8'd5, 8'h01, "reset_int_en");

    // 2. Packet then reads
    pkt(8'h09, 8'h50, 8'h3C, 1'b0);
    rd_expect(8'd0, 8'h09, "pkt_status");
    rd_expect(8'd1, 8'h50, "pkt_x");
    rd_expect(8'd2, 8'h3C, "pkt_y");
    chk("raise_pending", raise === 1'b1, {7'd0, raise}, 8'h01);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("raise_after_ack", raise === 1'b0, {7'd0, raise}, 8'h00);

    // 3. Coherence
    pkt(8'h01, 8'h10, 8'h00, 1'b0);
    rd_expect(8'd0, 8'h01, "coh_status1");
    pkt(8'h02, 8'h20, 8'h00, 1'b0);
    rd_expect(8'd1, 8'h10, "coh_x_old");
    rd_expect(8'd0, 8'h02, "coh_status2");
    rd_expect(8'd1, 8'h20, "coh_x_new");

    // 4. Overrun
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    rd_expect(8'd4, 8'h02, "ovr_clear_prev");
    pkt(8'h03, 8'h01, 8'h01, 1'b0);
    pkt(8'h04, 8'h02, 8'h02, 1'b0);
    rd_expect(8'd4, 8'h03, "ovr_set");
    rd_expect(8'd4, 8'h01, "ovr_cleared");
    pkt(8'h05, 8'h03, 8'h03, 1'b1);
    chk("send_ack_same_edge", raise === 1'b1, {7'd0, raise}, 8'h01);
    rd_expect(8'd4, 8'h01, "no_ovr_with_ack");
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

    // 5. Interrupt disable
    cyc(BASE + 8'd5, 1'b1, 8'hFE, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    rd_expect(8'd5, 8'h00, "int_en_cleared");
    pkt(8'h06, 8'h04, 8'h04, 1'b0);
    chk("raise_disabled", raise === 1'b0, {7'd0, raise}, 8'h00);
    rd_expect(8'd3, 8'h07, "pkt_cnt_7");
    idle();
    cyc(BASE + 8'd5, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    // 6. Out of window and write cycles stay Z; reset mid-drive
    cyc(BASE + 8'd6, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("out_of_window_z", bus_data === 8'hzz, bus_data, 8'h00);
    cyc(BASE + 8'd1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("write_cycle_z", bus_data === 8'hzz, bus_data, 8'h00);
    cyc(BASE + 8'd3, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("write_cycle_z2", bus_data === 8'hzz, bus_data, 8'h00);
    rd_expect(8'd3, 8'h07, "pre_reset_read");
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("reset_mid_drive_z", bus_data === 8'hzz, bus_data, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 256 packets wrap the counter
    for (int i = 0; i < 256; i++) pkt(8'(i), 8'(i + 1), 8'(i + 2), 1'b0);
    rd_expect(8'd3, 8'h00, "pkt_cnt_wrap");
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

    // Randomised traffic against the model
    prev_rd = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) a = 8'($urandom);
      else                           a = BASE + 8'($urandom_range(0, 7));
      we = prev_rd ? 1'b0 : ($urandom_range(0, 3) == 0);
      cyc(a, we, 8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom),
          8'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0));
      prev_rd = ((a - BASE) < 8'd6) && !we;
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mouse_bus_responder.md
Name: mouse_bus_responder

Overview:
- Read/write bus responder that presents the PS/2 mouse transceiver's latest packet to the microprocessor over the shared tri-state bus (BUS_ADDR, BUS_DATA, BUS_WE).
- It is the read-side counterpart of the write-only VGA peripheral on the same bus.
- It snapshots packets, guarantees coherent X/Y reads, counts packets, tracks overrun, and raises and holds the mouse interrupt until the processor acknowledges it.

Parameters:
- BASE_ADDR, 8'hA0, bus base address; the block decodes BASE_ADDR+0 through BASE_ADDR+5.

Ports:
- CLK  input  1  system clock (100 MHz).
- RESET  input  1  asynchronous, active-low reset.
- BUS_ADDR  input  8  bus address.
- BUS_DATA  inout  8  shared data bus; this block drives it only during a read of its own address window, otherwise 8'hZZ.
- BUS_WE  input  1  1 = write cycle, 0 = read cycle.
- MOUSE_STATUS  input  8  status byte from the transceiver.
- MOUSE_X  input  8  X position from the transceiver.
- MOUSE_Y  input  8  Y position from the transceiver.
- SEND_INTERRUPT  input  1  single-cycle pulse: new packet valid on MOUSE_* this cycle.
- BUS_INTERRUPT_RAISE  output  1  mouse interrupt request to the processor.
- BUS_INTERRUPT_ACK  input  1  single-cycle acknowledge from the processor.

Behaviour:
- Reset (RESET=0, async). All of the following clear immediately:
  - shadow regs, coherent X/Y, packet count, overrun: 0
  - int_en: 1
  - BUS_INTERRUPT_RAISE: 0
  - drive enable: 0, so BUS_DATA = Z
  - read data reg: 0
- Packet capture: on an edge with SEND_INTERRUPT=1:
  - shadow_status/x/y <= MOUSE_STATUS/X/Y.
  - pkt_cnt <= pkt_cnt+1, mod 256; 8'hFF wraps to 8'h00.
- Register map (offset from BASE_ADDR):
  - +0 R: shadow_status. The read also copies shadow_x/y into coherent_x/y.
  - +1 R: coherent_x.
  - +2 R: coherent_y.
  - +3 R: pkt_cnt.
  - +4 R: {6'b0, overrun, BUS_INTERRUPT_RAISE}. The read clears overrun.
  - +5 R/W: {7'b0, int_en}. A write stores BUS_DATA[0]; write data bits [7:1] are ignored.
  - Writes to +0 through +4 are ignored.
- Read timing:
  - Cycle N: BUS_ADDR in window and BUS_WE=0.
  - Edge at end of N: the read data reg loads the selected value as it stood before that edge's updates; drive enable <= 1.
  - Cycle N+1: BUS_DATA carries that value.
  - Drive enable is re-evaluated every edge, so a read lasts exactly one cycle per qualifying address cycle. Back-to-back reads are allowed.
- Out-of-window address or BUS_WE=1: drive enable <= 0 at the next edge, so this block never drives during a write cycle.
- Write timing: BUS_WE=1 with BUS_ADDR=+5 → int_en updates at that edge.
- Interrupt:
  - RAISE <= 1 on an edge with SEND_INTERRUPT=1 and int_en=1.
  - Else RAISE <= 0 on BUS_INTERRUPT_ACK=1.
  - Simultaneous SEND_INTERRUPT and ACK: RAISE stays 1 (the new event wins).
  - Clearing int_en does not drop a pending RAISE.
- Overrun: set on an edge where SEND_INTERRUPT=1, RAISE=1 and ACK=0. Same-edge set and read-clear: set wins.
- Simultaneous status read (+0) and SEND_INTERRUPT:
  - The read returns the old status.
  - coherent_x/y take the old shadow values.
  - The shadow registers take the new packet.
- Reset asserted mid-read: BUS_DATA releases to Z immediately (async).

Test Plan:
1. Reset → BUS_DATA = Z, RAISE=0; read +3 → 8'h00; read +5 → 8'h01.
2. SEND_INTERRUPT with status=8'h09, X=8'h50, Y=8'h3C; then read +0, +1, +2 → 8'h09, 8'h50, 8'h3C, each driven exactly one cycle after its address cycle; RAISE=1 until an ACK pulse, 0 the following cycle.
3. Coherence: send packet X=8'h10; read +0; send packet X=8'h20; read +1 → 8'h10; read +0 then +1 → 8'h20.
4. Overrun: two packets with no ACK → read +4 → 8'h03; read +4 again → 8'h01; same-edge packet+ACK leaves RAISE=1.
5. Write 8'h00 to +5, then a packet → RAISE stays 0 and pkt_cnt increments; 256 packets from reset → read +3 → 8'h00.
6. Read +1 at BASE_ADDR+6 and during BUS_WE=1 cycles → BUS_DATA = Z throughout; RESET=0 during a drive cycle → BUS_DATA goes to Z within the same cycle.
